// File: rtl/score_pkg.sv
// score_pkg: shared types and constants for the score digit scheduler
package score_pkg;
    typedef enum logic [1:0] {IDLE, CONVERT, HOLD} sched_state_t;
    typedef logic [3:0] bcd_digit_t;
    function automatic int max_value(input int digits);
        int v;
        v = 1;
        for (int i = 0; i < digits; i++) v = v * 10;
        return v - 1;
    endfunction
endpackage

// File: rtl/bcd_double_dabble.sv
// bcd_double_dabble: multi-cycle shift-add-3 binary to BCD converter
module bcd_double_dabble
    import score_pkg::*;
#(
    parameter int VAL_WIDTH  = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [VAL_WIDTH-1:0]    value,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);
    localparam int CW = $clog2(VAL_WIDTH + 1);
    logic [VAL_WIDTH-1:0]    shift;
    logic [CW-1:0]           count;
    logic [4*NUM_DIGITS-1:0] adj;
    bcd_digit_t              nib;
    assign done = busy && count == CW'(1);
    always_comb begin
        adj = bcd;
        nib = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = bcd[4*i +: 4];
            adj[4*i +: 4] = nib >= 4'd5 ? nib + 4'd3 : nib;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            count <= '0;
            shift <= '0;
            bcd   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= CW'(VAL_WIDTH);
            shift <= value;
            bcd   <= '0;
        end else if (busy) begin
            bcd   <= {adj[4*NUM_DIGITS-2:0], shift[VAL_WIDTH-1]};
            shift <= shift << 1;
            count <= count - 1'b1;
            busy  <= !done;
        end
    end
endmodule

// File: rtl/score_digit_scheduler.sv
// score_digit_scheduler: converts a score to BCD, commits it at frame start and steers a shared digit sprite
module score_digit_scheduler
    import score_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int VAL_WIDTH     = 14,
    parameter int DIGIT_W       = 24,
    parameter int BLANK_LEADING = 1
) (
    input  logic                 pixel_clk_in,
    input  logic                 rst_n_in,
    input  logic [VAL_WIDTH-1:0] value_in,
    input  logic                 value_valid_in,
    output logic                 value_ready_out,
    input  logic [10:0]          hcount_in,
    input  logic [9:0]           vcount_in,
    input  logic [10:0]          x_in,
    input  logic [9:0]           y_in,
    output logic [10:0]          hcount_out,
    output logic [9:0]           vcount_out,
    output logic [10:0]          sprite_x_out,
    output logic [9:0]           sprite_y_out,
    output logic [3:0]           number_out,
    output logic                 digit_en_out
);
    localparam int SW   = $clog2(NUM_DIGITS) + 1;
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int PW   = $clog2(DIGIT_W);
    localparam int MAXV = max_value(NUM_DIGITS);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(DIGIT_W - 1);

    sched_state_t            state;
    bcd_digit_t              disp [NUM_DIGITS];
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    dd_busy, dd_done, start, frame_start, run_zero;
    logic [VAL_WIDTH-1:0]    clamped;
    logic                    active, active_nx;
    logic [SW-1:0]           slot, slot_nx;
    logic [PW-1:0]           pix, pix_nx;
    logic [10:0]             xacc, xacc_nx;
    logic [NUM_DIGITS-1:0]   blank;

    assign start       = value_valid_in && value_ready_out;
    assign frame_start = hcount_in == '0 && vcount_in == '0;
    assign clamped     = 32'(value_in) > 32'(MAXV) ? VAL_WIDTH'(MAXV) : value_in;

    bcd_double_dabble #(.VAL_WIDTH(VAL_WIDTH), .NUM_DIGITS(NUM_DIGITS)) u_dd (
        .clk(pixel_clk_in), .rst_n(rst_n_in), .start(start), .value(clamped),
        .busy(dd_busy), .done(dd_done), .bcd(shadow)
    );

    // A slot is blank while every digit from the left up to it is zero; the last slot always shows.
    always_comb begin
        run_zero = BLANK_LEADING != 0;
        blank = '0;
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            run_zero = run_zero && disp[i] == '0;
            blank[i] = run_zero;
        end
    end

    always_comb begin
        active_nx = active;
        slot_nx   = slot;
        pix_nx    = pix;
        xacc_nx   = xacc;
        if (hcount_in == x_in) begin
            active_nx = 1'b1;
            slot_nx   = '0;
            pix_nx    = '0;
            xacc_nx   = x_in;
        end else if (hcount_in < x_in) begin
            active_nx = 1'b0;
        end else if (active) begin
            pix_nx = pix == PIX_LAST ? '0 : pix + 1'b1;
            if (pix == PIX_LAST) begin
                slot_nx   = slot + 1'b1;
                xacc_nx   = xacc + 11'(DIGIT_W);
                active_nx = slot != SLOT_LAST;
            end
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_n_in) begin
            state           <= IDLE;
            value_ready_out <= 1'b1;
            disp            <= '{default: '0};
            active          <= 1'b0;
            slot            <= '0;
            pix             <= '0;
            xacc            <= '0;
            hcount_out      <= '0;
            vcount_out      <= '0;
            sprite_y_out    <= '0;
        end else begin
            active       <= active_nx;
            slot         <= slot_nx;
            pix          <= pix_nx;
            xacc         <= xacc_nx;
            hcount_out   <= hcount_in;
            vcount_out   <= vcount_in;
            sprite_y_out <= y_in;
            unique case (state)
                IDLE: if (start) begin
                    state           <= CONVERT;
                    value_ready_out <= 1'b0;
                end
                CONVERT: if (dd_done || !dd_busy) state <= HOLD;
                HOLD: if (frame_start) begin
                    state           <= IDLE;
                    value_ready_out <= 1'b1;
                    for (int i = 0; i < NUM_DIGITS; i++) disp[i] <= shadow[4*(NUM_DIGITS-1-i) +: 4];
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign number_out   = slot < SW'(NUM_DIGITS) ? disp[slot[IW-1:0]] : '0;
    assign digit_en_out = active && !blank[slot[IW-1:0]];
    assign sprite_x_out = xacc;
endmodule

// File: tb/tb_score_digit_scheduler.sv
// tb_score_digit_scheduler: directed stimulus with a pixel-keyed scoreboard for score_digit_scheduler
module tb_score_digit_scheduler;
    logic        clk = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [13:0] value_in = '0;
    logic        value_valid_in = 1'b0;
    logic        value_ready_out;
    logic [10:0] hcount_in = 11'd500;
    logic [9:0]  vcount_in = 10'd5;
    logic [10:0] x_in = 11'd300;
    logic [9:0]  y_in = 10'd50;
    logic [10:0] hcount_out, sprite_x_out;
    logic [9:0]  vcount_out, sprite_y_out;
    logic [3:0]  number_out;
    logic        digit_en_out;

    typedef struct {
        int h;
        int v;
        bit full;
        int num;
        bit en;
        int sx;
    } rec_t;

    rec_t sb[$];
    rec_t mon_r;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   lag_chk = 1'b0;
    int   hp, vp;

    always #5 clk = ~clk;

    score_digit_scheduler dut (
        .pixel_clk_in(clk), .rst_n_in(rst_n_in), .value_in(value_in),
        .value_valid_in(value_valid_in), .value_ready_out(value_ready_out),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .x_in(x_in), .y_in(y_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out), .sprite_x_out(sprite_x_out),
        .sprite_y_out(sprite_y_out), .number_out(number_out), .digit_en_out(digit_en_out)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_px(input int h, input int v, input bit full, input int num, input bit en, input int sx);
        rec_t r;
        r.h = h; r.v = v; r.full = full; r.num = num; r.en = en; r.sx = sx;
        sb.push_back(r);
    endtask

    task automatic pix(input int h, input int v);
        @(negedge clk);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
    endtask

    task automatic idle(input int n);
        repeat (n) pix(500, 5);
    endtask

    task automatic send(input int v);
        @(negedge clk);
        chk("ready_before_send", value_ready_out, 1);
        value_in = 14'(v);
        value_valid_in = 1'b1;
        hcount_in = 11'd500;
        vcount_in = 10'd5;
        @(negedge clk);
        value_valid_in = 1'b0;
        chk("ready_after_accept", value_ready_out, 0);
    endtask

    task automatic commit();
        pix(0, 0);
        idle(1);
        chk("ready_after_commit", value_ready_out, 1);
    endtask

    task automatic scan(input int x, input int v, input logic [15:0] bcd, input logic [3:0] en);
        expect_px(x - 1, v, 1'b0, 0, 1'b0, 0);
        for (int s = 0; s < 4; s++) begin
            expect_px(x + s*24, v, 1'b1, int'(bcd[(3-s)*4 +: 4]), en[3-s], x + s*24);
            expect_px(x + s*24 + 23, v, 1'b1, int'(bcd[(3-s)*4 +: 4]), en[3-s], x + s*24);
        end
        expect_px(x + 96, v, 1'b0, 0, 1'b0, 0);
        for (int h = x - 2; h <= x + 97; h++) pix(h, v);
        idle(2);
    endtask

    // Outputs settle 1 time unit after the edge that registered the driven pixel.
    always @(posedge clk) begin
        hp = int'(hcount_in);
        vp = int'(vcount_in);
        #1;
        if (lag_chk) begin
            chk("hcount_lag", int'(hcount_out), hp);
            chk("vcount_lag", int'(vcount_out), vp);
        end
        if (sb.size() > 0 && int'(hcount_out) == sb[0].h && int'(vcount_out) == sb[0].v) begin
            mon_r = sb.pop_front();
            chk($sformatf("digit_en@h%0d", mon_r.h), digit_en_out, mon_r.en);
            if (mon_r.full) begin
                chk($sformatf("number@h%0d", mon_r.h), number_out, mon_r.num);
                chk($sformatf("sprite_x@h%0d", mon_r.h), sprite_x_out, mon_r.sx);
                chk($sformatf("sprite_y@h%0d", mon_r.h), sprite_y_out, int'(y_in));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", value_ready_out, 1);
        chk("rst_number", number_out, 0);
        chk("rst_digit_en", digit_en_out, 0);
        chk("rst_sprite_x", sprite_x_out, 0);
        chk("rst_sprite_y", sprite_y_out, 0);
        chk("rst_hcount", hcount_out, 0);
        chk("rst_vcount", vcount_out, 0);
        rst_n_in = 1'b1;
        idle(2);
        scan(300, 60, 16'h0000, 4'b0001);

        send(1234);
        idle(14);
        chk("ready_low_convert", value_ready_out, 0);
        commit();
        scan(300, 60, 16'h1234, 4'b1111);

        send(7);
        idle(14);
        commit();
        scan(300, 60, 16'h0007, 4'b0001);

        send(0);
        idle(14);
        commit();
        scan(300, 60, 16'h0000, 4'b0001);

        send(12000);
        idle(14);
        commit();
        scan(300, 60, 16'h9999, 4'b1111);

        x_in = 11'd100;
        expect_px(0, 100, 1'b0, 0, 1'b0, 0);
        expect_px(99, 100, 1'b0, 0, 1'b0, 0);
        expect_px(100, 100, 1'b1, 9, 1'b1, 100);
        expect_px(195, 100, 1'b1, 9, 1'b1, 172);
        expect_px(196, 100, 1'b0, 0, 1'b0, 0);
        expect_px(1279, 100, 1'b0, 0, 1'b0, 0);
        lag_chk = 1'b1;
        for (int h = 0; h < 1280; h++) pix(h, 100);
        idle(2);
        lag_chk = 1'b0;
        x_in = 11'd300;
        idle(2);

        send(8765);
        idle(2);
        pix(0, 0);
        idle(1);
        chk("ready_low_after_early_frame", value_ready_out, 0);
        scan(300, 60, 16'h9999, 4'b1111);
        commit();
        scan(300, 60, 16'h8765, 4'b1111);

        send(42);
        idle(14);
        @(negedge clk);
        value_in = 14'd999;
        value_valid_in = 1'b1;
        chk("ready_low_hold", value_ready_out, 0);
        @(negedge clk);
        value_valid_in = 1'b0;
        commit();
        idle(3);
        chk("ready_stays_idle", value_ready_out, 1);
        scan(300, 60, 16'h0042, 4'b0011);

        send(5555);
        idle(4);
        @(negedge clk);
        rst_n_in = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_ready", value_ready_out, 1);
        chk("midrst_digit_en", digit_en_out, 0);
        chk("midrst_number", number_out, 0);
        chk("midrst_sprite_x", sprite_x_out, 0);
        chk("midrst_sprite_y", sprite_y_out, 0);
        chk("midrst_hcount", hcount_out, 0);
        @(negedge clk);
        rst_n_in = 1'b1;
        idle(20);
        chk("midrst_ready_after", value_ready_out, 1);
        pix(0, 0);
        idle(1);
        scan(300, 60, 16'h0000, 4'b0001);

        idle(3);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/score_digit_scheduler.md
# score_digit_scheduler

Sequencer that shares one `numbers.mem` digit-sprite instance across a row of decimal digit slots. It accepts a binary score and converts it to BCD with a multi-cycle shift-add-3 engine. It commits the digits to the display only at frame start, so the display never tears. Per pixel it tells the shared sprite which digit image to draw and where, and it blanks leading zeros. It sits between game logic (score source) and the number sprite in the video pipeline.

## Interface
Parameters:
- `NUM_DIGITS`, 4: digit slots, most significant slot leftmost.
- `VAL_WIDTH`, 14: width of the binary input value.
- `DIGIT_W`, 24: pixel pitch of one slot; equals the sprite WIDTH.
- `BLANK_LEADING`, 1: 1 suppresses leading zeros.

Ports:
- `pixel_clk_in`  in  1: pixel clock; the only clock.
- `rst_n_in`  in  1: reset, synchronous, active-low.
- `value_in`  in  VAL_WIDTH: binary value to display.
- `value_valid_in`  in  1: `value_in` is valid.
- `value_ready_out`  out  1: block can accept a value.
- `hcount_in`  in  11: current pixel column.
- `vcount_in`  in  10: current pixel row.
- `x_in`  in  11: left edge of slot 0.
- `y_in`  in  10: top edge of the digit row.
- `hcount_out`  out  11: `hcount_in` delayed 1 cycle.
- `vcount_out`  out  10: `vcount_in` delayed 1 cycle.
- `sprite_x_out`  out  11: x position for the sprite, aligned to `hcount_out`.
- `sprite_y_out`  out  10: equals registered `y_in`.
- `number_out`  out  4: BCD digit (0-9) for the sprite `number` input.
- `digit_en_out`  out  1: the current slot is visible and not blanked. Final draw is `draw_out && digit_en_out`.

## Operation
- FSM states:
  - IDLE:
    - `value_ready_out`=1.
    - On `value_valid_in && value_ready_out`: capture `value_in`, clamp values above 10^NUM_DIGITS−1 to all nines, clear the BCD shadow, go to CONVERT.
  - CONVERT:
    - Runs exactly VAL_WIDTH cycles of double-dabble into a shadow BCD register.
    - Each cycle: add 3 to every nibble ≥5, then shift in one MSB.
    - After the final cycle, go to HOLD.
  - HOLD:
    - Waits for the frame-start condition (`hcount_in`==0 && `vcount_in`==0).
    - On that cycle: copy the shadow BCD into the display register, go to IDLE.
  - `value_ready_out`=0 in CONVERT and HOLD; input valid is ignored there.
- Slot tracker:
  - On `hcount_in`==`x_in`: slot counter and pixel counter are set to 0, and the active flag is set.
  - Each subsequent cycle the pixel counter increments. At DIGIT_W−1 it wraps to 0 and the slot counter increments.
  - After slot NUM_DIGITS−1 wraps, active clears.
  - `hcount_in` < `x_in` also clears active.
- Outputs, registered from the tracker:
  - `number_out` = display digit for the slot (slot 0 = most significant).
  - `sprite_x_out` = `x_in` + slot·DIGIT_W, computed by an accumulator: add DIGIT_W at each slot wrap, no multiplier.
  - `digit_en_out` = active && not blanked.
- Blanking, when BLANK_LEADING=1: slot i is blanked iff it and all more-significant digits are zero. The least significant slot is never blanked, so 0 displays as "0".
- Arithmetic: the slot counter is `$clog2(NUM_DIGITS)`+1 bits. The x accumulator is 11 bits and wraps modulo 2048 with no saturation.

## Timing
- Reset values:
  - FSM=IDLE, `value_ready_out`=1.
  - Display digits all 0.
  - `number_out`=0, `digit_en_out`=0.
  - `sprite_x_out`=0, `sprite_y_out`=0.
  - `hcount_out`=0, `vcount_out`=0.
- Reset mid-CONVERT or mid-HOLD: the pending value is discarded and the display is cleared to 0.
- Accept to commit:
  - Accept happens at cycle 0.
  - Shadow BCD is ready after VAL_WIDTH cycles.
  - Commit happens at the next frame start after that, with no fixed upper bound.
  - If frame start occurs during CONVERT, commit waits for the following frame.
- Pixel path latency is 1 cycle. All pixel outputs correspond to `hcount_out`/`vcount_out`, which drive the sprite's `hcount_in`/`vcount_in`.
- A commit cycle coinciding with an active slot cannot occur, since `x_in` > 0 is required; `x_in`=0 is unsupported.

## Structure
- Package `score_pkg`:
  - FSM state enum `sched_state_t` {IDLE, CONVERT, HOLD}.
  - `bcd_digit_t` (logic [3:0]).
  - Function computing the clamp constant 10^N−1.
- Sub-module `bcd_double_dabble`:
  - Ports: start, value, busy, done, bcd out.
  - Parameterised by VAL_WIDTH and NUM_DIGITS.
  - Instantiated once.

## Test plan
- Reset, then send `value_in`=1234: `value_ready_out` low for 14+ cycles. After the next frame start, scanning row `y_in` gives `number_out` 1,2,3,4 with `sprite_x_out` = x, x+24, x+48, x+72 and `digit_en_out`=1 throughout.
- Send `value_in`=7 with BLANK_LEADING=1: slots 0-2 have `digit_en_out`=0; slot 3 shows 7. Send 0: only slot 3 is enabled, showing 0.
- Send `value_in`=12000: display clamps to 9999.
- Send `value_in` so that frame start falls mid-CONVERT: the display keeps the old value that frame and shows the new one the frame after. A `value_valid_in` pulse during HOLD is ignored.
- Deassert `rst_n_in` during CONVERT: outputs go to reset values next cycle, the display shows 0, and `value_ready_out`=1.
- Scan `hcount_in` 0..1279 with `x_in`=100: `digit_en_out` is high exactly for `hcount_out` 100..195. `hcount_out` lags `hcount_in` by exactly 1 cycle.
